// File: rtl/fc_input_loader.sv
// Double-buffered activation loader: serial WIDTH-bit beats -> IN-entry parallel vector x for the FC layer.
// Latency: completing beat at cycle t -> x_valid at t+1 when its bank is presented, else the cycle after the prior release.
// Backpressure: in_ready drops only when both banks are full; x/x_valid hold steady until x_ready releases the vector.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data/in_valid/in_last/in_ready   serial activation stream (valid/ready, in_last closes a vector)
//   x[0:IN-1], x_valid, x_ready         presented vector and its release handshake
//   frame_err           one-cycle pulse when a vector's length does not equal IN
module fc_input_loader #(
    parameter int WIDTH = 8,
    parameter int IN    = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] x [IN],
    output logic             x_valid,
    input  logic             x_ready,
    output logic             frame_err
);

    localparam int             CW       = (IN > 1) ? $clog2(IN) : 1;
    localparam logic [CW-1:0]  LAST_IDX = CW'(IN - 1);

    logic [WIDTH-1:0] bank_q [2][IN];
    logic [1:0]       full_q, full_d;
    logic             wsel_q, wsel_d;
    logic             rsel_q, rsel_d;
    logic [CW-1:0]    wcnt_q, wcnt_d;
    logic             frame_err_q, frame_err_d;

    logic accept;
    logic at_end;
    logic complete;
    logic release_vec;

    // Everything visible to the neighbours comes straight from registers.
    assign in_ready    = ~full_q[wsel_q];
    assign x_valid     = full_q[rsel_q];
    assign frame_err   = frame_err_q;

    assign accept      = in_valid & in_ready;
    assign at_end      = (wcnt_q == LAST_IDX);
    assign complete    = accept & (in_last | at_end);
    assign release_vec = full_q[rsel_q] & x_ready;

    always_comb begin
        for (int i = 0; i < IN; i++) begin
            x[i] = bank_q[rsel_q][i];
        end
    end

    // A completing bank is always empty and a released bank always full,
    // so the two updates below never target the same flag.
    always_comb begin
        full_d      = full_q;
        wsel_d      = wsel_q;
        rsel_d      = rsel_q;
        wcnt_d      = wcnt_q;
        frame_err_d = 1'b0;
        if (accept) begin
            wcnt_d      = complete ? '0 : wcnt_q + CW'(1);
            // Error when the frame ends early or runs to IN without in_last.
            frame_err_d = in_last ^ at_end;
        end
        if (complete) begin
            full_d[wsel_q] = 1'b1;
            wsel_d         = ~wsel_q;
        end
        if (release_vec) begin
            full_d[rsel_q] = 1'b0;
            rsel_d         = ~rsel_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= '0;
            wsel_q      <= 1'b0;
            rsel_q      <= 1'b0;
            wcnt_q      <= '0;
            frame_err_q <= 1'b0;
        end else begin
            full_q      <= full_d;
            wsel_q      <= wsel_d;
            rsel_q      <= rsel_d;
            wcnt_q      <= wcnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Bank write: the addressed entry takes the beat; on an early in_last the
    // remaining tail of the same bank is zeroed in that cycle so stale data
    // from an older vector never reaches the layer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < IN; i++) begin
                    bank_q[b][i] <= '0;
                end
            end
        end else if (accept) begin
            for (int b = 0; b < 2; b++) begin
                if (wsel_q == 1'(b)) begin
                    for (int i = 0; i < IN; i++) begin
                        if (CW'(i) == wcnt_q) begin
                            bank_q[b][i] <= in_data;
                        end else if (in_last && (CW'(i) > wcnt_q)) begin
                            bank_q[b][i] <= '0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fc_input_loader.sv
module tb_fc_input_loader;

    localparam int W = 8;
    localparam int N = 128;
    localparam int NVEC = 1000;
    localparam int RAND_BUDGET = 80000;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [W-1:0] x [N];
    logic         x_valid;
    logic         x_ready;
    logic         frame_err;

    int checks   = 0;
    int failures = 0;

    logic [N*W-1:0] exp_q [$];

    fc_input_loader #(.WIDTH(W), .IN(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .x         (x),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] xpack();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = x[i];
        return r;
    endfunction

    function automatic int x_mismatch(input logic [N*W-1:0] e);
        int cnt = 0;
        for (int i = 0; i < N; i++) if (x[i] !== e[i*W +: W]) cnt++;
        return cnt;
    endfunction

    function automatic logic [N*W-1:0] fill_vec(input logic [W-1:0] v);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = v;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and return just after the edge that accepted it.
    task automatic send_beat(input logic [W-1:0] d, input logic l);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && waited < 500) begin
            cyc();
            waited++;
        end
        if (!in_ready) check_val("beat_timeout", 32'd0, 32'd1);
        cyc();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_release();
        x_ready = 1'b1;
        cyc();
        x_ready = 1'b0;
    endtask

    initial begin
        logic [N*W-1:0] e;
        logic [N*W-1:0] snap;
        int unstable;
        int ferr_seen;
        int nz;

        rst_n    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        x_ready  = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        nz = 0;
        for (int i = 0; i < N; i++) if (x[i] != '0) nz++;
        check_val("rst_x_valid", 32'(x_valid), 32'd0);
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_frame_err", 32'(frame_err), 32'd0);
        check_val("rst_x_nonzero", 32'(nz), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Single vector 0..127, x_ready held low
        ferr_seen = 0;
        for (int i = 0; i < N; i++) begin
            send_beat(W'(i), i == N - 1);
            if (frame_err) ferr_seen++;
        end
        for (int i = 0; i < N; i++) e[i*W +: W] = W'(i);
        check_val("single_x_valid", 32'(x_valid), 32'd1);
        check_val("single_x_data", 32'(x_mismatch(e)), 32'd0);
        snap = xpack();
        unstable = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (xpack() !== snap || !x_valid) unstable++;
            if (frame_err) ferr_seen++;
        end
        check_val("single_stable", 32'(unstable), 32'd0);
        check_val("single_no_ferr", 32'(ferr_seen), 32'd0);
        pulse_release();
        check_val("single_released", 32'(x_valid), 32'd0);

        // Back-to-back A (0x11) then B (0x22), no release
        for (int i = 0; i < N; i++) send_beat(8'h11, i == N - 1);
        for (int i = 0; i < N; i++) send_beat(8'h22, i == N - 1);
        check_val("b2b_in_ready_stall", 32'(in_ready), 32'd0);
        check_val("b2b_x_is_A", 32'(x_mismatch(fill_vec(8'h11))), 32'd0);
        pulse_release();
        check_val("b2b_x_valid_B", 32'(x_valid), 32'd1);
        check_val("b2b_x_is_B", 32'(x_mismatch(fill_vec(8'h22))), 32'd0);
        check_val("b2b_in_ready_back", 32'(in_ready), 32'd1);

        // Completion of C lands in the same cycle B is released
        for (int i = 0; i < N - 1; i++) send_beat(8'h33, 1'b0);
        x_ready = 1'b1;
        send_beat(8'h33, 1'b1);
        x_ready = 1'b0;
        check_val("simul_x_valid", 32'(x_valid), 32'd1);
        check_val("simul_x_is_C", 32'(x_mismatch(fill_vec(8'h33))), 32'd0);
        check_val("simul_in_ready", 32'(in_ready), 32'd1);
        pulse_release();
        check_val("simul_drained", 32'(x_valid), 32'd0);

        // Short frame 1..10 into a bank that still holds 0x22
        for (int i = 0; i < 10; i++) send_beat(W'(i + 1), i == 9);
        check_val("short_ferr_pulse", 32'(frame_err), 32'd1);
        e = '0;
        for (int i = 0; i < 10; i++) e[i*W +: W] = W'(i + 1);
        check_val("short_x_valid", 32'(x_valid), 32'd1);
        check_val("short_x_data", 32'(x_mismatch(e)), 32'd0);
        cyc();
        check_val("short_ferr_one_cycle", 32'(frame_err), 32'd0);
        for (int i = 0; i < N; i++) send_beat(W'(i) ^ 8'h5A, i == N - 1);
        pulse_release();
        for (int i = 0; i < N; i++) e[i*W +: W] = W'(i) ^ 8'h5A;
        check_val("after_short_x_data", 32'(x_mismatch(e)), 32'd0);
        pulse_release();
        check_val("after_short_drained", 32'(x_valid), 32'd0);
        repeat (2) cyc();

        // Random throttling on both sides against a reference queue
        begin
            int n = 0;
            int len;
            bit use_last;
            int sent = 0;
            int recv = 0;
            int cycles = 0;
            int ferr_exp = 0;
            int ferr_got = 0;
            bit err_pend = 1'b0;
            bit is_end;
            logic [N*W-1:0] cur = '0;
            logic [N*W-1:0] xv;
            logic [N*W-1:0] ev;
            int k;
            int r;

            r = $urandom_range(0, 19);
            len = (r < 2) ? N : $urandom_range(1, 12);
            use_last = (r != 0);

            while (recv < NVEC && cycles < RAND_BUDGET) begin
                if (sent < NVEC) begin
                    in_valid = ($urandom_range(0, 9) < 7);
                    in_data  = W'($urandom);
                    in_last  = use_last && (n == len - 1);
                end else begin
                    in_valid = 1'b0;
                    in_last  = 1'b0;
                end
                x_ready = 1'($urandom_range(0, 1));
                @(negedge clk);

                check_val("rand_frame_err", 32'(frame_err), 32'(err_pend));
                if (frame_err) ferr_got++;
                err_pend = 1'b0;

                if (in_valid && in_ready) begin
                    cur[n*W +: W] = in_data;
                    is_end = (n == N - 1);
                    if (in_last || is_end) begin
                        err_pend = in_last ^ is_end;
                        if (err_pend) ferr_exp++;
                        exp_q.push_back(cur);
                        cur = '0;
                        n = 0;
                        sent++;
                        r = $urandom_range(0, 19);
                        len = (r < 2) ? N : $urandom_range(1, 12);
                        use_last = (r != 0);
                    end else begin
                        n++;
                    end
                end

                if (x_valid && x_ready) begin
                    if (exp_q.size() == 0) begin
                        check_val("rand_unexpected_vec", 32'd1, 32'd0);
                    end else begin
                        xv = xpack();
                        ev = exp_q.pop_front();
                        k = 0;
                        for (int i = 0; i < N; i++) begin
                            if (xv[i*W +: W] !== ev[i*W +: W]) begin
                                k = i;
                                break;
                            end
                        end
                        check_val($sformatf("rand_vec%0d_idx%0d", recv, k), 32'(xv[k*W +: W]), 32'(ev[k*W +: W]));
                    end
                    recv++;
                end

                @(posedge clk);
                #1;
                cycles++;
            end
            x_ready  = 1'b0;
            in_valid = 1'b0;
            check_val("rand_vectors_delivered", 32'(recv), 32'(NVEC));
            check_val("rand_queue_empty", 32'(exp_q.size()), 32'd0);
            check_val("rand_ferr_total", 32'(ferr_got), 32'(ferr_exp));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
